dmem_arbiter: RTL and testbench

Two-requester round-robin arbiter sharing the single-port word-addressed data memory between the core load/store unit (port 0) and the DMA/loader (port 1). It accepts at most one request per cycle with a valid/ready handshake and drives the memory's write enable, address and write data. It registers read data into a one-cycle response and flags misaligned or out-of-range accesses. A lock mechanism gives one port back-to-back beats, bounded by a watchdog.

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters,
// with per-port lock (watchdog-bounded), address checking and registered responses.
module dmem_arbiter #(
    parameter int unsigned DEPTH    = 1000,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_we,
    input  logic [1:0]       req_lock,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_wdata,
    output logic [1:0]       rsp_valid,
    output logic [1:0]       rsp_err,
    output logic [1:0][31:0] rsp_rdata,
    output logic             dm_en,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    input  logic [31:0]      dm_rdata
);

    localparam int unsigned     CNT_W      = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
    localparam logic [31:0]     ADDR_LIMIT = 32'(DEPTH * 4);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             last_grant_nxt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;
    logic             sel;
    logic [1:0]       addr_err;
    logic             dm_sel;

    // Misaligned or beyond the last word.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            addr_err[i] = (req_addr[i][1:0] != 2'b00) || (req_addr[i] >= ADDR_LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lock_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            lock_cnt   <= lock_cnt_nxt;
        end
    end

    always_comb begin
        req_ready      = '0;
        state_nxt      = state;
        last_grant_nxt = last_grant;
        lock_cnt_nxt   = lock_cnt;
        sel            = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_valid == 2'b11) begin
                    sel = ~last_grant;
                end else begin
                    sel = req_valid[1];
                end
                req_ready[sel] = req_valid[sel];
            end
            LOCK0: begin
                sel          = 1'b0;
                req_ready[0] = req_valid[0];
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end
            LOCK1: begin
                sel          = 1'b1;
                req_ready[1] = req_valid[1];
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase

        if (rst) begin
            req_ready = '0;
        end

        if (|req_ready) begin
            last_grant_nxt = sel;
            if (state == IDLE && req_lock[sel]) begin
                state_nxt    = sel ? LOCK1 : LOCK0;
                lock_cnt_nxt = '0;
            end else if (state != IDLE && !req_lock[sel]) begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        end

        // Watchdog: forced release hands the next contention to the other port.
        if (state != IDLE && lock_cnt == CNT_LAST) begin
            state_nxt      = IDLE;
            last_grant_nxt = sel;
            lock_cnt_nxt   = '0;
        end
    end

    // Memory drive follows the granted port, port 0 when idle.
    assign dm_sel   = req_ready[1];
    assign dm_addr  = req_addr[dm_sel];
    assign dm_wdata = req_wdata[dm_sel];
    assign dm_en    = (|req_ready) && req_we[dm_sel] && !addr_err[dm_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_err   <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= req_ready;
            for (int i = 0; i < 2; i++) begin
                rsp_err[i]   <= req_ready[i] & addr_err[i];
                rsp_rdata[i] <= (req_ready[i] && !req_we[i] && !addr_err[i]) ? dm_rdata : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of grants, locks and memory contents.
module tb_dmem_arbiter;

    localparam int          DEPTH    = 1000;
    localparam int          MAX_LOCK = 16;
    localparam logic [31:0] LIMIT    = 32'(DEPTH * 4);

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0]       req_lock;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_err;
    logic [1:0][31:0] rsp_rdata;
    logic             dm_en;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_wdata;
    logic [31:0]      dm_rdata;

    dmem_arbiter #(.DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .dm_en(dm_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic bit bad_addr(logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= LIMIT);
    endfunction

    // Memory attached to the DUT: asynchronous read, write at the clock edge.
    logic [31:0] mem [DEPTH];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pattern(i);
            mem_init <= 1'b1;
        end else if (dm_en && dm_addr < LIMIT) begin
            mem[int'(dm_addr >> 2)] <= dm_wdata;
        end
    end
    always_comb dm_rdata = (dm_addr < LIMIT) ? mem[int'(dm_addr >> 2)] : 32'h0;

    // Reference model: who owns a lock, how long it has been held, who won last.
    logic [31:0]      ref_mem [DEPTH];
    int               m_owner = -1;
    int               m_held  = 0;
    int               m_last  = 1;
    int               exp_g   = -1;
    logic [1:0]       exp_ready;
    logic             exp_dm_en;
    logic [31:0]      exp_dm_addr;
    logic [31:0]      exp_dm_wdata;
    logic [1:0]       exp_rsp_valid = '0;
    logic [1:0]       exp_rsp_err   = '0;
    logic [1:0][31:0] exp_rsp_rdata = '0;

    int tests = 0;
    int fails = 0;

    task automatic model_eval();
        exp_g = -1;
        if (!rst) begin
            if (m_owner >= 0) begin
                if (req_valid[m_owner]) exp_g = m_owner;
            end else if (req_valid == 2'b11) begin
                exp_g = 1 - m_last;
            end else if (req_valid[0]) begin
                exp_g = 0;
            end else if (req_valid[1]) begin
                exp_g = 1;
            end
        end
        exp_ready    = (exp_g < 0) ? 2'b00 : ((exp_g == 0) ? 2'b01 : 2'b10);
        exp_dm_addr  = (exp_g == 1) ? req_addr[1] : req_addr[0];
        exp_dm_wdata = (exp_g == 1) ? req_wdata[1] : req_wdata[0];
        exp_dm_en    = 1'b0;
        if (exp_g >= 0) exp_dm_en = req_we[exp_g] && !bad_addr(req_addr[exp_g]);
    endtask

    task automatic model_commit();
        exp_rsp_valid = '0;
        exp_rsp_err   = '0;
        exp_rsp_rdata = '0;
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 1;
            return;
        end
        if (exp_g >= 0) begin
            exp_rsp_valid[exp_g] = 1'b1;
            if (bad_addr(req_addr[exp_g])) exp_rsp_err[exp_g] = 1'b1;
            else if (req_we[exp_g]) ref_mem[req_addr[exp_g] / 4] = req_wdata[exp_g];
            else exp_rsp_rdata[exp_g] = ref_mem[req_addr[exp_g] / 4];
        end
        if (m_owner >= 0) begin
            if (m_held == MAX_LOCK - 1) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (exp_g == m_owner && !req_lock[exp_g]) begin
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else if (exp_g >= 0 && req_lock[exp_g]) begin
            m_owner = exp_g;
            m_held  = 0;
        end
        if (exp_g >= 0) m_last = exp_g;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(int p, bit v, bit we, bit lk, logic [31:0] a, logic [31:0] wd);
        req_valid[p] = v;
        req_we[p]    = we;
        req_lock[p]  = lk;
        req_addr[p]  = a;
        req_wdata[p] = wd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_port(0, 0, 0, 0, 32'h0, 32'h0);
        set_port(1, 0, 0, 0, 32'h0, 32'h0);
        settle();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_port(0, 1, 1, 0, 32'h20, 32'h1111_1111);
        set_port(1, 1, 1, 0, 32'h24, 32'h2222_2222);
        settle();
        tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        tests++; if (dm_en !== 1'b0) begin fails++; $display("FAIL reset_dm_en: got %b want 0", dm_en); end
        advance();
        tests++; if (rsp_valid !== 2'b00 || rsp_err !== 2'b00) begin fails++; $display("FAIL reset_rsp: got valid %b err %b want 00 00", rsp_valid, rsp_err); end
        tests++; if (rsp_rdata !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        set_port(0, 1, 0, 0, 32'h0, 32'h0);
        set_port(1, 1, 0, 0, 32'h4, 32'h0);
        for (int k = 0; k < 8; k++) begin
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            settle();
            tests++; if (req_ready !== want) begin fails++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, want); end
            advance();
            tests++; if (rsp_valid !== want) begin fails++; $display("FAIL rr_rsp_valid[%0d]: got %b want %b", k, rsp_valid, want); end
            tests++; if (rsp_rdata !== exp_rsp_rdata) begin fails++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, rsp_rdata, exp_rsp_rdata); end
        end
    endtask

    task automatic test_raw();
        set_port(0, 1, 1, 0, 32'h10, 32'hDEAD_BEEF);
        set_port(1, 0, 0, 0, 32'h0, 32'h0);
        settle();
        tests++; if (dm_en !== 1'b1 || dm_addr !== 32'h10 || dm_wdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL raw_write: got en %b addr %h data %h want 1 10 deadbeef", dm_en, dm_addr, dm_wdata); end
        advance();
        set_port(0, 0, 0, 0, 32'h0, 32'h0);
        set_port(1, 1, 0, 0, 32'h10, 32'h0);
        settle();
        tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL raw_grant: got %b want 10", req_ready); end
        advance();
        tests++; if (rsp_valid[1] !== 1'b1 || rsp_err[1] !== 1'b0 || rsp_rdata[1] !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL raw_read: got v %b e %b data %h want 1 0 deadbeef", rsp_valid[1], rsp_err[1], rsp_rdata[1]); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [2];
        addrs[0] = 32'h2;
        addrs[1] = LIMIT;
        for (int k = 0; k < 2; k++) begin
            set_port(0, 0, 0, 0, 32'h0, 32'h0);
            set_port(1, 1, 1, 0, addrs[k], 32'h1234_5678);
            settle();
            tests++; if (req_ready !== 2'b10 || dm_en !== 1'b0) begin
                fails++; $display("FAIL err_accept[%0d]: got ready %b en %b want 10 0", k, req_ready, dm_en); end
            advance();
            tests++; if (rsp_valid !== 2'b10 || rsp_err !== 2'b10 || rsp_rdata[1] !== 32'h0) begin
                fails++; $display("FAIL err_rsp[%0d]: got v %b e %b data %h want 10 10 0", k, rsp_valid, rsp_err, rsp_rdata[1]); end
        end
        tests++; if (mem[0] !== pattern(0)) begin fails++; $display("FAIL err_mem: got %h want %h", mem[0], pattern(0)); end
    endtask

    task automatic test_lock_beats();
        bit lk [4] = '{1, 1, 1, 0};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) set_port(0, 1, 0, lk[k], 32'(k * 4), 32'h0);
            else       set_port(0, 0, 0, 0, 32'h0, 32'h0);
            set_port(1, 1, 0, 0, 32'h40, 32'h0);
            settle();
            tests++; if (req_ready !== ((k < 4) ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL lock_grant[%0d]: got %b want %b", k, req_ready, (k < 4) ? 2'b01 : 2'b10); end
            advance();
        end
    endtask

    task automatic test_forced_release();
        int blocked = 0;
        do_reset();
        set_port(0, 1, 0, 1, 32'h8, 32'h0);
        set_port(1, 1, 0, 0, 32'hC, 32'h0);
        settle();
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL wd_first: got %b want 01", req_ready); end
        advance();
        set_port(0, 0, 0, 0, 32'h0, 32'h0);
        for (int k = 0; k < MAX_LOCK + 4 && req_ready !== 2'b10; k++) begin
            settle();
            if (req_ready !== 2'b10) begin
                blocked++;
                if (blocked == MAX_LOCK) set_port(0, 1, 0, 0, 32'h8, 32'h0);
                advance();
            end
        end
        tests++; if (blocked != MAX_LOCK || req_ready !== 2'b10) begin
            fails++; $display("FAIL wd_release: got blocked %0d ready %b want %0d 10", blocked, req_ready, MAX_LOCK); end
        advance();
        set_port(1, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        set_port(0, 0, 0, 0, 32'h0, 32'h0);
        set_port(1, 1, 0, 1, 32'h8, 32'h0);
        settle(); advance();
        set_port(1, 1, 0, 1, 32'hC, 32'h0);
        settle();
        tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL rml_locked: got %b want 10", req_ready); end
        advance();
        rst = 1'b1;
        settle();
        tests++; if (rsp_valid !== 2'b10 || req_ready !== 2'b00) begin
            fails++; $display("FAIL rml_pending: got v %b ready %b want 10 00", rsp_valid, req_ready); end
        advance();
        tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL rml_cleared: got %b want 00", rsp_valid); end
        rst = 1'b0;
        set_port(0, 1, 0, 0, 32'h0, 32'h0);
        set_port(1, 1, 0, 0, 32'h4, 32'h0);
        settle();
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL rml_first: got %b want 01", req_ready); end
        advance();
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                r = int'($urandom_range(0, 9));
                set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                         (r < 8) ? 32'($urandom_range(0, 15)) * 4 :
                         (r == 8) ? 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3)) :
                         LIMIT + 32'($urandom_range(0, 7)) * 4,
                         $urandom);
            end
            settle();
            tests++; if (req_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, exp_ready); end
            tests++; if (dm_en !== exp_dm_en) begin fails++; $display("FAIL rnd_dm_en[%0d]: got %b want %b", c, dm_en, exp_dm_en); end
            tests++; if (dm_addr !== exp_dm_addr || dm_wdata !== exp_dm_wdata) begin
                fails++; $display("FAIL rnd_dm_bus[%0d]: got %h/%h want %h/%h", c, dm_addr, dm_wdata, exp_dm_addr, exp_dm_wdata); end
            advance();
            tests++; if (rsp_valid !== exp_rsp_valid || rsp_err !== exp_rsp_err) begin
                fails++; $display("FAIL rnd_rsp[%0d]: got v %b e %b want %b %b", c, rsp_valid, rsp_err, exp_rsp_valid, exp_rsp_err); end
            tests++; if (rsp_rdata !== exp_rsp_rdata) begin
                fails++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rsp_rdata, exp_rsp_rdata); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pattern(i);
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_round_robin();
        test_raw();
        test_errors();
        test_lock_beats();
        test_forced_release();
        test_reset_mid_lock();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
